// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- E-stage multiply/divide unit with HI/LO registers.
//
// mult/multu/div/divu are accepted in one cycle: the full 64-bit result is
// computed at accept and parked in a pending register, a busy counter then
// runs for MULT_CYCLES or DIV_CYCLES, and HI/LO take the pending value on the
// edge where the counter leaves 1. mthi/mtlo write HI/LO directly when idle;
// mfhi/mflo read HI/LO combinationally.
//
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu (codes 8..11),
// 64-bit wrapping accumulate on the HI/LO value seen at accept.
//
// Ports:
//   clk      in   1   pipeline clock
//   rst_n    in   1   asynchronous active-low reset
//   sel_mdu  in   4   op code (0 mult,1 multu,2 div,3 divu,4 mfhi,5 mflo,
//                     6 mthi,7 mtlo, others none)
//   cancel   in   1   exception taken; suppresses start and mt writes
//   rs_val   in   32  rs operand / mt data
//   rt_val   in   32  rt operand
//   start    out  1   a multi-cycle op is accepted this cycle (comb)
//   busy     out  1   a multi-cycle op is in flight
//   mdu_out  out  32  HI for mfhi, LO for mflo, else 0 (comb)
//   hi       out  32  HI register
//   lo       out  32  LO register
// -----------------------------------------------------------------------------
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sel_mdu,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic [CNT_W-1:0] cnt_r;

    logic             is_md_s;
    logic             is_mult_s;
    logic             busy_s;
    logic             accept_s;
    logic [63:0]      hilo_s;
    logic [63:0]      prod_sgn_s;
    logic [63:0]      prod_uns_s;
    logic [31:0]      rs_mag_s;
    logic [31:0]      rt_mag_s;
    logic [31:0]      q_mag_s;
    logic [31:0]      r_mag_s;
    logic [31:0]      q_sgn_s;
    logic [31:0]      r_sgn_s;
    logic [31:0]      q_uns_s;
    logic [31:0]      r_uns_s;
    logic [63:0]      result_s;
    logic [CNT_W-1:0] cnt_load_s;

    assign busy_s = (cnt_r != {CNT_W{1'b0}});
    assign hilo_s = {hi_r, lo_r};

    // Classify the op code: multi-cycle or not, and which latency it uses.
    always_comb begin
        is_md_s   = 1'b0;
        is_mult_s = 1'b0;
        case (sel_mdu)
            OP_MULT, OP_MULTU: begin
                is_md_s   = 1'b1;
                is_mult_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                is_md_s   = 1'b1;
                is_mult_s = 1'b0;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                is_md_s   = 1'b1;
                is_mult_s = 1'b1;
            end
`endif
            default: begin
                is_md_s   = 1'b0;
                is_mult_s = 1'b0;
            end
        endcase
    end

    assign accept_s   = is_md_s & ~busy_s & ~cancel;
    assign cnt_load_s = is_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    // Products: sign-extending to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    assign prod_sgn_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_uns_s = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed division on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    assign rs_mag_s = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign rt_mag_s = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    assign q_mag_s  = rs_mag_s / rt_mag_s;
    assign r_mag_s  = rs_mag_s % rt_mag_s;
    assign q_sgn_s  = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    assign r_sgn_s  = rs_val[31] ? (32'd0 - r_mag_s) : r_mag_s;
    assign q_uns_s  = rs_val / rt_val;
    assign r_uns_s  = rs_val % rt_val;

    // Select the 64-bit value HI/LO will take when the op commits; a zero
    // divisor re-commits the current HI/LO so they appear unchanged.
    always_comb begin
        result_s = hilo_s;
        case (sel_mdu)
            OP_MULT:  result_s = prod_sgn_s;
            OP_MULTU: result_s = prod_uns_s;
            OP_DIV: begin
                if (rt_val != 32'd0) begin
                    result_s = {r_sgn_s, q_sgn_s};
                end else begin
                    result_s = hilo_s;
                end
            end
            OP_DIVU: begin
                if (rt_val != 32'd0) begin
                    result_s = {r_uns_s, q_uns_s};
                end else begin
                    result_s = hilo_s;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result_s = hilo_s + prod_sgn_s;
            OP_MADDU: result_s = hilo_s + prod_uns_s;
            OP_MSUB:  result_s = hilo_s - prod_sgn_s;
            OP_MSUBU: result_s = hilo_s - prod_uns_s;
`endif
            default:  result_s = hilo_s;
        endcase
    end

    // Busy counter, pending result and HI/LO updates (commit or mt write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            cnt_r     <= {CNT_W{1'b0}};
        end else if (busy_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end
        end else if (accept_s) begin
            pend_hi_r <= result_s[63:32];
            pend_lo_r <= result_s[31:0];
            cnt_r     <= cnt_load_s;
        end else if (!cancel && sel_mdu == OP_MTHI) begin
            hi_r <= rs_val;
        end else if (!cancel && sel_mdu == OP_MTLO) begin
            lo_r <= rs_val;
        end
    end

    // Move-from read path into the E->M result bus.
    always_comb begin
        mdu_out = 32'd0;
        case (sel_mdu)
            OP_MFHI: mdu_out = hi_r;
            OP_MFLO: mdu_out = lo_r;
            default: mdu_out = 32'd0;
        endcase
    end

    assign start = accept_s;
    assign busy  = busy_s;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule
